// File: rtl/timer_reg_master.sv
// Single-outstanding register-access master for the timer peripheral: validates the
// address map, runs one bus access with a grant timeout, and returns a response.
module timer_reg_master #(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [P_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [P_DATA_WIDTH-1:0] cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [P_DATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_error,
  output logic                    bus_req,
  output logic                    bus_write,
  output logic [P_ADDR_WIDTH-1:0] bus_addr,
  output logic [P_DATA_WIDTH-1:0] bus_wdata,
  input  logic                    bus_gnt,
  input  logic [P_DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(P_TIMEOUT - 1);

  state_t                  state_reg, state_next;
  logic                    alive_reg;
  logic [7:0]              cnt_reg;
  logic                    write_reg;
  logic [P_ADDR_WIDTH-1:0] addr_reg;
  logic [P_DATA_WIDTH-1:0] wdata_reg;
  logic [P_DATA_WIDTH-1:0] rdata_reg;
  logic                    error_reg;

  logic accept;
  logic addr_mapped;
  logic is_count;
  logic legal;
  logic timed_out;

  // Map is 0x00..0x0C word-aligned; 0x0C (COUNT) is read-only.
  assign addr_mapped = (cmd_addr[1:0] == 2'b00) && ((cmd_addr >> 4) == '0);
  assign is_count    = (cmd_addr[3:2] == 2'b11);
  assign legal       = addr_mapped && !(cmd_write && is_count);
  assign accept      = cmd_valid && cmd_ready;
  assign timed_out   = (cnt_reg == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = legal ? BUS : RESP;
      BUS:  if (bus_gnt || timed_out) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // alive_reg holds cmd_ready low until the first edge after reset release.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    bus_req   = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready = alive_reg;
      BUS:     bus_req   = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_reg <= 1'b0;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            write_reg <= cmd_write;
            addr_reg  <= cmd_addr;
            wdata_reg <= cmd_wdata;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            error_reg <= !legal;
          end
        end
        BUS: begin
          // A grant on the last permitted cycle still wins over the timeout.
          if (bus_gnt) begin
            rdata_reg <= write_reg ? '0 : bus_rdata;
            error_reg <= 1'b0;
          end else if (timed_out) begin
            rdata_reg <= '0;
            error_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_write = write_reg;
  assign bus_addr  = addr_reg;
  assign bus_wdata = wdata_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_error = error_reg;

endmodule

// File: tb/tb_timer_reg_master.sv
// Scoreboard bench for timer_reg_master: expected responses are queued at command
// time and compared when the response handshake happens.
module tb_timer_reg_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 6;
  localparam int NEVER = 1000;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          bus_req;
  logic          bus_write;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_gnt;
  logic [DW-1:0] bus_rdata;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_txn   = 0;

  timer_reg_master #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command end to end. gnt_wait = bus cycles before grant (NEVER = no grant).
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic legal, input int gnt_wait, input logic [DW-1:0] rdata,
                        input int stall);
    rsp_t exp;
    rsp_t got;
    int   cycles;
    int   exp_cycles;
    logic [DW-1:0] held_rdata;
    logic          held_err;

    if (!legal || gnt_wait >= TO) begin
      exp.rdata = '0;
      exp.err   = 1'b1;
    end else begin
      exp.rdata = wr ? '0 : rdata;
      exp.err   = 1'b0;
    end
    sb_q.push_back(exp);

    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    step();
    cmd_valid = 1'b0;
    cmd_wdata = ~wdata;
    cmd_addr  = ~addr;

    if (legal) begin
      chk("bus_req_lat", 64'(bus_req), 64'd1);
      chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
      exp_cycles = (gnt_wait < TO) ? gnt_wait + 1 : TO;
      cycles = 0;
      while (bus_req && cycles < TO + 4) begin
        chk("bus_write", 64'(bus_write), 64'(wr));
        chk("bus_addr", 64'(bus_addr), 64'(addr));
        chk("bus_wdata", 64'(bus_wdata), 64'(wdata));
        bus_gnt   = (cycles == gnt_wait);
        bus_rdata = bus_gnt ? rdata : DW'($urandom);
        step();
        cycles++;
      end
      bus_gnt = 1'b0;
      chk("bus_cycles", 64'(cycles), 64'(exp_cycles));
    end else begin
      chk("bus_req_illegal", 64'(bus_req), 64'd0);
    end
    chk("rsp_valid_lat", 64'(rsp_valid), 64'd1);

    held_rdata = rsp_rdata;
    held_err   = rsp_error;
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      step();
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("stall_rdata", 64'(rsp_rdata), 64'(held_rdata));
      chk("stall_err", 64'(rsp_error), 64'(held_err));
      chk("stall_bus_req", 64'(bus_req), 64'd0);
    end
    cmd_valid = 1'b0;

    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      got.rdata = rsp_rdata;
      got.err   = rsp_error;
      chk("rsp_rdata", 64'(got.rdata), 64'(exp.rdata));
      chk("rsp_error", 64'(got.err), 64'(exp.err));
      $display("txn %0d: wr=%0d addr=%02h rdata=%08h err=%0d", n_txn, wr, addr,
               got.rdata, got.err);
    end
    n_txn++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_done", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
    chk("bus_req_done", 64'(bus_req), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; bus_gnt = 1'b0; bus_rdata = '0;

    #3;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
    #19;
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready_pre", 64'(cmd_ready), 64'd0);
    step();
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    // Grant while idle must not produce anything.
    bus_gnt = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    step();
    step();
    bus_gnt = 1'b0;
    chk("gnt_idle_rsp", 64'(rsp_valid), 64'd0);
    chk("gnt_idle_req", 64'(bus_req), 64'd0);
    chk("gnt_idle_rdy", 64'(cmd_ready), 64'd1);

    do_cmd(1'b1, 8'h00, 32'h0000_0003, 1'b1, 0,     32'h0,         0);
    do_cmd(1'b0, 8'h0C, 32'h0,         1'b1, 3,     32'h0000_ABCD, 0);
    do_cmd(1'b1, 8'h0C, 32'h1111_2222, 1'b0, 0,     32'h0,         0);
    do_cmd(1'b0, 8'h05, 32'h0,         1'b0, 0,     32'h0,         0);
    do_cmd(1'b0, 8'h08, 32'h0,         1'b1, NEVER, 32'h0,         0);
    do_cmd(1'b0, 8'h08, 32'h0,         1'b1, TO-1,  32'h0000_1234, 0);
    do_cmd(1'b0, 8'h04, 32'h0,         1'b1, 1,     32'h5555_AAAA, 5);
    do_cmd(1'b1, 8'h08, 32'hCAFE_F00D, 1'b1, 2,     32'hFFFF_FFFF, 0);
    do_cmd(1'b0, 8'h10, 32'h0,         1'b0, 0,     32'h0,         0);
    do_cmd(1'b1, 8'h40, 32'h7,         1'b0, 0,     32'h0,         2);
    do_cmd(1'b0, 8'h84, 32'h0,         1'b0, 0,     32'h0,         0);
    do_cmd(1'b0, 8'h00, 32'h0,         1'b1, 0,     32'h8765_4321, 1);

    // Reset in the middle of a bus access.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_bus_req", 64'(bus_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(bus_req), 64'd0);
    chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    chk("mid_rst_addr", 64'(bus_addr), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    chk("mid_rel_rdy_pre", 64'(cmd_ready), 64'd0);
    step();
    chk("mid_rel_rdy", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
      chk("mid_no_req", 64'(bus_req), 64'd0);
    end

    do_cmd(1'b1, 8'h04, 32'h0000_00FF, 1'b1, 1, 32'h0, 0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
